// File: rtl/tmr_pkg.sv
// rtl/tmr_pkg.sv - shared TMR types, defaults and width helper
package tmr_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    // Bit counter width for 0..w-1; kept at least 1 bit so WIDTH=2 still works
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/tmr_sat_counter.sv
// rtl/tmr_sat_counter.sv - saturating event counter, clear beats increment
module tmr_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/tmr_word_collector.sv
// rtl/tmr_word_collector.sv - packs voted TMR bits MSB-first into handshaked words
module tmr_word_collector
    import tmr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             bit_err,
    input  logic             clear_stats,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_err,
    output logic [CNT_W-1:0] err_count,
    output logic             overflow
);

    localparam int BC_W = cnt_width(WIDTH);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic [BC_W-1:0]  bit_cnt;
    logic             part_err;
    hold_state_t      state;

    logic             word_done;
    logic [WIDTH-1:0] next_word;
    logic             next_err;

    assign word_done  = bit_valid && (bit_cnt == LAST_BIT);
    assign next_word  = {shreg[WIDTH-2:0], bit_in};
    assign next_err   = part_err | bit_err;
    assign word_valid = (state == HOLD_FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            part_err <= 1'b0;
            state    <= HOLD_EMPTY;
            word_out <= '0;
            word_err <= 1'b0;
        end else begin
            if (bit_valid) begin
                shreg <= next_word;
                if (word_done) begin
                    bit_cnt  <= '0;
                    part_err <= 1'b0;
                end else begin
                    bit_cnt  <= bit_cnt + BC_W'(1);
                    part_err <= next_err;
                end
            end

            // A new word replaces the held one only if it is free or draining now
            case (state)
                HOLD_EMPTY: begin
                    if (word_done) begin
                        word_out <= next_word;
                        word_err <= next_err;
                        state    <= HOLD_FULL;
                    end
                end
                default: begin
                    if (word_done) begin
                        if (word_ready) begin
                            word_out <= next_word;
                            word_err <= next_err;
                        end
                    end else if (word_ready) begin
                        state <= HOLD_EMPTY;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            overflow <= 1'b0;
        end else if (word_done && (state == HOLD_FULL) && !word_ready) begin
            overflow <= 1'b1;
        end
    end

    tmr_sat_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bit_valid & bit_err),
        .clr   (clear_stats),
        .count (err_count)
    );

endmodule

// File: tb/tb_tmr_word_collector.sv
// tb/tb_tmr_word_collector.sv - randomized and directed checks against a word-level model
module tb_tmr_word_collector;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         bit_valid;
    logic         bit_in;
    logic         bit_err;
    logic         clear_stats;
    logic         word_ready;
    logic         word_valid,  word_valid4;
    logic [W-1:0] word_out,    word_out4;
    logic         word_err,    word_err4;
    logic [7:0]   err_count;
    logic [3:0]   err_count4;
    logic         overflow,    overflow4;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    bit     m_bits[$];
    bit     m_perr;
    bit     m_valid;
    int     m_word;
    bit     m_werr;
    int     m_errs8;
    int     m_errs4;
    bit     m_ovf;

    tmr_word_collector #(.WIDTH(W), .CNT_W(8)) dut (
        .clk (clk), .reset (reset), .bit_valid (bit_valid), .bit_in (bit_in),
        .bit_err (bit_err), .clear_stats (clear_stats), .word_valid (word_valid),
        .word_ready (word_ready), .word_out (word_out), .word_err (word_err),
        .err_count (err_count), .overflow (overflow)
    );

    tmr_word_collector #(.WIDTH(W), .CNT_W(4)) dut4 (
        .clk (clk), .reset (reset), .bit_valid (bit_valid), .bit_in (bit_in),
        .bit_err (bit_err), .clear_stats (clear_stats), .word_valid (word_valid4),
        .word_ready (word_ready), .word_out (word_out4), .word_err (word_err4),
        .err_count (err_count4), .overflow (overflow4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_update(input bit rst, input bit bv, input bit b, input bit be,
                                input bit rdy, input bit clr);
        bit done;
        int wv;
        bit we;
        if (rst) begin
            m_bits.delete();
            m_perr = 0; m_valid = 0; m_word = 0; m_werr = 0;
            m_errs8 = 0; m_errs4 = 0; m_ovf = 0;
            return;
        end
        done = 0; wv = 0; we = 0;
        if (bv) begin
            m_bits.push_back(b);
            m_perr = m_perr | be;
            if (be) begin
                m_errs8 = (m_errs8 + 1 > 255) ? 255 : m_errs8 + 1;
                m_errs4 = (m_errs4 + 1 > 15) ? 15 : m_errs4 + 1;
            end
            if (m_bits.size() == W) begin
                foreach (m_bits[i]) wv = wv * 2 + int'(m_bits[i]);
                we = m_perr;
                done = 1;
                m_bits.delete();
                m_perr = 0;
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_word = wv; m_werr = we; m_valid = 1;
            end else begin
                m_ovf = 1;
            end
        end else if (rdy) begin
            m_valid = 0;
        end
        if (clr) begin
            m_errs8 = 0; m_errs4 = 0; m_ovf = 0;
        end
    endtask

    task automatic step(input bit rst, input bit bv, input bit b, input bit be,
                        input bit rdy, input bit clr);
        reset = rst; bit_valid = bv; bit_in = b; bit_err = be;
        word_ready = rdy; clear_stats = clr;
        @(posedge clk);
        model_update(rst, bv, b, be, rdy, clr);
        #1;
        check("word_valid", word_valid, m_valid);
        check("word_valid4", word_valid4, m_valid);
        if (m_valid) begin
            check("word_out", word_out, m_word);
            check("word_err", word_err, m_werr);
            check("word_out4", word_out4, m_word);
        end
        check("err_count", err_count, m_errs8);
        check("err_count4", err_count4, m_errs4);
        check("overflow", overflow, m_ovf);
        check("overflow4", overflow4, m_ovf);
    endtask

    // Sends one word MSB-first; rdy_last applies only to the final bit
    task automatic send_word(input logic [7:0] w, input logic [7:0] em, input bit rdy,
                             input bit rdy_last, input int gap, input bit clr_last);
        for (int i = W - 1; i >= 0; i--) begin
            step(0, 1, w[i], em[i], (i == 0) ? rdy_last : rdy, (i == 0) ? clr_last : 1'b0);
            for (int g = 0; g < gap; g++) step(0, 0, 0, 1, 0, 0);
        end
    endtask

    initial begin
        reset = 1; bit_valid = 0; bit_in = 0; bit_err = 0; word_ready = 0; clear_stats = 0;

        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_word_valid", word_valid, 0);
        check("rst_word_out", word_out, 0);
        check("rst_word_err", word_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_overflow", overflow, 0);

        // basic word 1,0,1,1,0,0,1,0
        send_word(8'hB2, 8'h00, 1, 1, 0, 0);
        check("b2_valid", word_valid, 1);
        check("b2_word", word_out, 8'hB2);
        check("b2_err", word_err, 0);
        check("b2_cnt", err_count, 0);

        // error on third bit only, then a clean word
        send_word(8'hB2, 8'h20, 1, 1, 0, 0);
        check("err_word_err", word_err, 1);
        check("err_cnt1", err_count, 1);
        send_word(8'h00, 8'h00, 1, 1, 0, 0);
        check("clean_word_err", word_err, 0);
        step(0, 0, 0, 0, 1, 0);
        check("drained", word_valid, 0);

        // back-pressure and overflow
        send_word(8'hA5, 8'h00, 0, 0, 0, 0);
        send_word(8'h3C, 8'h00, 0, 0, 0, 0);
        check("ovf_hold_word", word_out, 8'hA5);
        check("ovf_flag", overflow, 1);
        step(0, 0, 0, 0, 1, 0);
        check("ovf_drained", word_valid, 0);

        // simultaneous completion and drain
        step(0, 0, 0, 0, 0, 1);
        send_word(8'h11, 8'h00, 0, 0, 0, 0);
        send_word(8'h22, 8'h00, 0, 1, 0, 0);
        check("sim_word", word_out, 8'h22);
        check("sim_valid", word_valid, 1);
        check("sim_ovf", overflow, 0);
        step(0, 0, 0, 0, 1, 0);

        // gapped input
        send_word(8'h5A, 8'h00, 0, 0, 1, 0);
        check("gap_word", word_out, 8'h5A);
        step(0, 0, 0, 0, 1, 0);

        // reset mid-word
        for (int i = 0; i < 5; i++) step(0, 1, 1'(i & 1), 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        send_word(8'hFF, 8'h00, 0, 0, 0, 0);
        check("rst_mid_word", word_out, 8'hFF);
        check("rst_mid_valid", word_valid, 1);

        // clear_stats against errored bit plus overflow in the same cycle
        send_word(8'h0F, 8'h81, 0, 0, 0, 1);
        check("clr_cnt", err_count, 0);
        check("clr_ovf", overflow, 0);
        check("clr_keep_word", word_out, 8'hFF);
        step(0, 0, 0, 0, 1, 0);

        // saturation of the 4-bit counter
        step(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 1'($urandom_range(0, 1)), 1, 1, 0);
        check("sat_cnt4", err_count4, 15);
        check("sat_cnt8", err_count, 20);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 79) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/tmr_word_collector.md
# tmr_word_collector

Deserialiser that sits directly downstream of the 1-bit TMR voter. It consumes the voted bit stream and per-bit TMR error flag, and packs WIDTH voted bits MSB-first into words. Completed words go out through a valid/ready handshake, each tagged with a per-word error flag. The block also keeps a saturating TMR error counter and a sticky overflow flag for the status logic.

## Interface
Parameters:
- WIDTH, 8, bits per assembled word (≥2)
- CNT_W, 8, width of error counter

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- bit_valid  in  1  voted bit present this cycle
- bit_in  in  1  voted data bit (voter data_out)
- bit_err  in  1  voter TMR_error for this bit
- clear_stats  in  1  clears err_count and overflow
- word_valid  out  1  word_out holds an unconsumed word
- word_ready  in  1  consumer accepts word_out
- word_out  out  WIDTH  assembled word, first bit received in MSB
- word_err  out  1  at least one bit of word_out had bit_err=1
- err_count  out  CNT_W  number of accepted bits with bit_err=1, saturating
- overflow  out  1  sticky: a completed word was dropped

## Operation
- Bit accept: when bit_valid=1, shift bit_in into the shift register LSB (shreg <= {shreg[WIDTH-2:0], bit_in}). OR bit_err into the partial-word error bit. Increment bit_cnt (0..WIDTH-1). bit_valid is never back-pressured.
- Word complete: a bit accepted with bit_cnt==WIDTH-1 completes the word. bit_cnt wraps to 0, and the partial error bit clears for the next word.
- Output holding register, two states:
  - EMPTY: word_valid=0.
  - FULL: word_valid=1, word_out/word_err stable.
- Transitions on word complete:
  - EMPTY→FULL: load the word.
  - FULL with word_ready=1 the same cycle: load the new word, stay FULL, no overflow.
  - FULL with word_ready=0: drop the new word, keep the old word, set overflow.
- FULL→EMPTY: word_ready=1 and no word completes that cycle.
- word_ready while EMPTY is ignored.
- err_count: +1 per accepted bit with bit_err=1. Holds at 2^CNT_W−1. bit_err with bit_valid=0 is ignored.
- clear_stats: err_count←0 and overflow←0. Clear wins over a simultaneous increment or overflow event. Does not affect shift register, bit_cnt, or holding register.
- Reset values: word_valid=0, word_out=0, word_err=0, err_count=0, overflow=0. Internally bit_cnt=0, shreg=0, partial error=0.
- Reset mid-word discards the partial word. Reset while FULL discards the held word.

## Timing
- Latency: the last bit accepted in cycle N gives word_valid=1 with the word on word_out in cycle N+1.
- Sustained throughput: one word per WIDTH cycles with bit_valid held at 1.
- Handshake: transfer occurs on the rising edge where word_valid&&word_ready. word_out/word_err must not change while word_valid=1 and word_ready=0.
- err_count and overflow update one cycle after the causing event.
- No combinational path from inputs to outputs. All outputs are registered.

## Structure
- Shared package tmr_pkg:
  - enum typedef hold_state_t {HOLD_EMPTY, HOLD_FULL}
  - function clog2-based width for bit_cnt
  - default WIDTH/CNT_W constants, shared with the voter and fault-injection bench
- One sub-module is natural: tmr_sat_counter (CNT_W parameter, inc, clr inputs, clr priority). It is reusable for per-channel fault counts.
- Rest is a single module: shift register, bit counter, holding register FSM.

## Test plan
- Reset/basic word: WIDTH=8, word_ready=1, stream bits 1,0,1,1,0,0,1,0 on consecutive cycles with bit_err=0 → word_valid one cycle after the 8th bit, word_out=8'hB2, word_err=0, err_count=0.
- Error tagging and saturation:
  - Same stream with bit_err=1 on bit 3 only → word_err=1, err_count=1, next clean word has word_err=0.
  - With CNT_W=4, 20 errored bits → err_count=15.
- Back-pressure/overflow: word_ready=0, send two full words (8'hA5 then 8'h3C) → word_out stays 8'hA5, overflow=1 after the 16th bit. Then word_ready=1 → 8'hA5 transferred, word_valid=0.
- Simultaneous complete and drain: hold 8'h11 with word_ready=0. Raise word_ready in exactly the cycle the last bit of 8'h22 is accepted → next cycle word_out=8'h22, word_valid=1, overflow=0.
- Gapped input and reset mid-word:
  - bit_valid toggling 1/0 still assembles 8'h5A correctly.
  - Assert reset after 5 bits, then send 8'hFF → word_out=8'hFF, no residue.
- clear_stats priority: assert clear_stats in the same cycle as an errored bit and an overflow event → err_count=0 and overflow=0 the next cycle.
